// File: rtl/bitpair_term_scheduler_pkg.sv
// Shared types and helpers for the bit-pair term scheduler.
// Optional signed mode is enabled by BITPAIR_TERM_SCHEDULER_SIGNED_EN.
package bitpair_term_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LAT_MIN = 1;

    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bitpair_ffs.sv
// Lowest-set-bit finder: binary index of the least significant 1 plus a nonzero flag.
module bitpair_ffs #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             nz_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        nz_o = |vec_i;
    end

endmodule

// File: rtl/bitpair_term_scheduler.sv
// Bit-serial partial-product term scheduler walking only set bits of A (outer) and B (inner).
// Define BITPAIR_TERM_SCHEDULER_SIGNED_EN to weight sign-bit terms negatively (two's complement).
//
// state | meaning
// IDLE  | waiting for a request; req_ready follows enable
// ISSUE | presenting the current (a,b) bit pair on the term port
// WAIT  | term in flight, counting down the programmed latency
// DONE  | one-cycle completion pulse, then back to IDLE
module bitpair_term_scheduler
    import bitpair_term_scheduler_pkg::*;
#(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int LAT_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [A_WIDTH-1:0]          req_a,
    input  logic [B_WIDTH-1:0]          req_b,
    input  logic [LAT_WIDTH-1:0]        req_latency,
    output logic                        term_valid,
    input  logic                        term_ready,
    output logic [idx_w(A_WIDTH)-1:0]   term_a_idx,
    output logic [idx_w(B_WIDTH)-1:0]   term_b_idx,
    output logic                        term_neg,
    output logic                        retire_pulse,
    output logic                        row_done,
    output logic                        done,
    output logic                        busy
);

    localparam int AIW = idx_w(A_WIDTH);
    localparam int BIW = idx_w(B_WIDTH);
    localparam logic [LAT_WIDTH-1:0] LAT_ONE = LAT_WIDTH'(LAT_MIN);

    state_t               state_q,    state_d;
    logic [A_WIDTH-1:0]   a_mask_q,   a_mask_d;
    logic [B_WIDTH-1:0]   b_mask_q,   b_mask_d;
    logic [B_WIDTH-1:0]   b_reload_q, b_reload_d;
    logic [LAT_WIDTH-1:0] lat_cnt_q,  lat_cnt_d;
    logic [LAT_WIDTH-1:0] lat_q,      lat_d;

    logic [AIW-1:0]       a_idx;
    logic [BIW-1:0]       b_idx;
    logic                 a_nz;
    logic                 b_nz;
    logic [A_WIDTH-1:0]   a_onehot;
    logic [B_WIDTH-1:0]   b_onehot;
    logic [A_WIDTH-1:0]   a_rest;
    logic [B_WIDTH-1:0]   b_rest;
    logic                 lat_hit;
    logic                 live;
    logic                 neg_raw;

    bitpair_ffs #(.WIDTH(A_WIDTH), .IDX_W(AIW)) u_ffs_a (
        .vec_i (a_mask_q),
        .idx_o (a_idx),
        .nz_o  (a_nz)
    );

    bitpair_ffs #(.WIDTH(B_WIDTH), .IDX_W(BIW)) u_ffs_b (
        .vec_i (b_mask_q),
        .idx_o (b_idx),
        .nz_o  (b_nz)
    );

    // Masks with the current term's bit removed.
    always_comb begin
        a_onehot        = '0;
        a_onehot[a_idx] = 1'b1;
        b_onehot        = '0;
        b_onehot[b_idx] = 1'b1;
        a_rest          = a_mask_q & ~a_onehot;
        b_rest          = b_mask_q & ~b_onehot;
        lat_hit         = (lat_cnt_q == LAT_ONE);
    end

`ifdef BITPAIR_TERM_SCHEDULER_SIGNED_EN
    localparam logic [AIW-1:0] A_MSB = AIW'(A_WIDTH - 1);
    localparam logic [BIW-1:0] B_MSB = BIW'(B_WIDTH - 1);
    assign neg_raw = (a_idx == A_MSB) ^ (b_idx == B_MSB);
`else
    assign neg_raw = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_mask_q   <= '0;
            b_mask_q   <= '0;
            b_reload_q <= '0;
            lat_cnt_q  <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_mask_q   <= a_mask_d;
            b_mask_q   <= b_mask_d;
            b_reload_q <= b_reload_d;
            lat_cnt_q  <= lat_cnt_d;
            lat_q      <= lat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_mask_d   = a_mask_q;
        b_mask_d   = b_mask_q;
        b_reload_d = b_reload_q;
        lat_cnt_d  = lat_cnt_q;
        lat_d      = lat_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_mask_d   = req_a;
                        b_mask_d   = req_b;
                        b_reload_d = req_b;
                        lat_d      = (req_latency < LAT_ONE) ? LAT_ONE : req_latency;
                        state_d    = ((req_a == '0) || (req_b == '0)) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (term_ready) begin
                        lat_cnt_d = lat_q;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt_d = lat_cnt_q - LAT_ONE;
                    if (lat_hit) begin
                        if (b_rest == '0) begin
                            a_mask_d = a_rest;
                            b_mask_d = b_reload_q;
                            state_d  = (a_rest == '0) ? DONE : ISSUE;
                        end else begin
                            b_mask_d = b_rest;
                            state_d  = ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        live         = enable & ~rst;
        req_ready    = live & (state_q == IDLE);
        busy         = (state_q != IDLE);
        term_valid   = (state_q == ISSUE) & a_nz & b_nz;
        term_a_idx   = a_idx;
        term_b_idx   = b_idx;
        term_neg     = neg_raw & (state_q == ISSUE);
        retire_pulse = live & (state_q == WAIT) & lat_hit;
        row_done     = retire_pulse & (b_rest == '0);
        done         = live & (state_q == DONE);
    end

endmodule

// File: tb/tb_bitpair_term_scheduler.sv
// Self-checking bench for bitpair_term_scheduler: vector table plus scoreboard of expected events.
module tb_bitpair_term_scheduler;

`ifdef BITPAIR_TERM_SCHEDULER_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable = 1'b1;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_latency;
    logic       term_valid;
    logic       term_ready;
    logic [2:0] term_a_idx;
    logic [2:0] term_b_idx;
    logic       term_neg;
    logic       retire_pulse;
    logic       row_done;
    logic       done;
    logic       busy;

    always #5 clk = ~clk;

    bitpair_term_scheduler #(.A_WIDTH(8), .B_WIDTH(8), .LAT_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_latency  (req_latency),
        .term_valid   (term_valid),
        .term_ready   (term_ready),
        .term_a_idx   (term_a_idx),
        .term_b_idx   (term_b_idx),
        .term_neg     (term_neg),
        .retire_pulse (retire_pulse),
        .row_done     (row_done),
        .done         (done),
        .busy         (busy)
    );

    typedef struct {
        int cyc;
        int ai;
        int bi;
        bit neg;
    } term_t;

    typedef struct {
        int cyc;
        bit row;
    } ret_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] lat;
        bit         rnd;
        int         done_rel;
    } vec_t;

    term_t exp_term[$];
    ret_t  exp_ret[$];
    int    exp_done[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ecyc = 0;
    int c0 = 0;
    int stall_cfg = 0;
    int last_done_rel = -1;
    bit rand_en = 1'b0;

    // Time base in enabled cycles, so freezing with enable=0 is transparent to the model.
    always @(posedge clk) if (enable) ecyc <= ecyc + 1;

    always @(posedge clk) begin
        #1;
        enable = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (ecyc %0d)", name, act, exp, ecyc);
        end
    endtask

    function automatic void push_expect(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] lat, input int base, input int stall);
        int l;
        int t;
        int hi_b;
        l    = (lat == 4'd0) ? 1 : int'(lat);
        t    = base + 1 + stall;
        hi_b = -1;
        for (int j = 0; j < 8; j++) if (b[j]) hi_b = j;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) begin
                for (int j = 0; j < 8; j++) begin
                    if (b[j]) begin
                        term_t tt;
                        ret_t  rr;
                        tt.cyc = t;
                        tt.ai  = i;
                        tt.bi  = j;
                        tt.neg = SIGNED_MODE && ((i == 7) != (j == 7));
                        exp_term.push_back(tt);
                        rr.cyc = t + l;
                        rr.row = (j == hi_b);
                        exp_ret.push_back(rr);
                        t = t + l + 1;
                    end
                end
            end
        end
        if (a == 8'h00 || b == 8'h00) exp_done.push_back(base + 1);
        else                          exp_done.push_back(t);
    endfunction

    // Monitor: pops the scoreboard on every observed event, pushes on every accepted request.
    always @(negedge clk) begin
        if (term_valid && term_ready && enable) begin
            chk("term_pending", int'(exp_term.size() > 0), 1);
            if (exp_term.size() > 0) begin
                term_t e;
                e = exp_term.pop_front();
                chk("term_cycle", ecyc - c0, e.cyc - c0);
                chk("term_a_idx", int'(term_a_idx), e.ai);
                chk("term_b_idx", int'(term_b_idx), e.bi);
                chk("term_neg", int'(term_neg), int'(e.neg));
            end
        end
        if (retire_pulse) begin
            chk("retire_pending", int'(exp_ret.size() > 0), 1);
            if (exp_ret.size() > 0) begin
                ret_t r;
                r = exp_ret.pop_front();
                chk("retire_cycle", ecyc - c0, r.cyc - c0);
                chk("row_done", int'(row_done), int'(r.row));
            end
        end else if (row_done) begin
            chk("row_done_without_retire", int'(row_done), 0);
        end
        if (done) begin
            chk("done_pending", int'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) begin
                int d;
                d = exp_done.pop_front();
                chk("done_cycle", ecyc - c0, d - c0);
            end
            last_done_rel = ecyc - c0;
        end
        if (!enable && rand_en) chk("req_ready_frozen", int'(req_ready), 0);
        if (req_valid && req_ready) begin
            c0 = ecyc;
            push_expect(req_a, req_b, req_latency, ecyc, stall_cfg);
        end
        if (rst) begin
            exp_term.delete();
            exp_ret.delete();
            exp_done.delete();
        end
    end

    task automatic drive_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] lat);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_a       = a;
        req_b       = b;
        req_latency = lat;
        req_valid   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_accepted", int'(ok), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (!busy && exp_term.size() == 0 && exp_ret.size() == 0 && exp_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_in_budget", int'(ok), 1);
        @(posedge clk); #1;
    endtask

    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h05, 8'h03, 4'd3,  1'b0, 17};
        vecs[1] = '{8'h00, 8'hFF, 4'd5,  1'b0, 1};
        vecs[2] = '{8'hFF, 8'h00, 4'd5,  1'b0, 1};
        vecs[3] = '{8'h01, 8'h01, 4'd0,  1'b0, 3};
        vecs[4] = '{8'h80, 8'h81, 4'd2,  1'b0, 7};
        vecs[5] = '{8'hFF, 8'hFF, 4'd1,  1'b0, 129};
        vecs[6] = '{8'h81, 8'h80, 4'd15, 1'b0, 33};
        vecs[7] = '{8'h10, 8'h80, 4'd7,  1'b0, 9};
        vecs[8] = '{8'h5A, 8'h33, 4'd2,  1'b1, 49};

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_a       = 8'h00;
        req_b       = 8'h00;
        req_latency = 4'd0;
        term_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("req_ready_in_reset", int'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_term_valid", int'(term_valid), 0);
        chk("reset_retire", int'(retire_pulse), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_a_idx", int'(term_a_idx), 0);
        chk("reset_b_idx", int'(term_b_idx), 0);
        chk("reset_term_neg", int'(term_neg), 0);
        chk("idle_req_ready", int'(req_ready), 1);

        for (int v = 0; v < 9; v++) begin
            rand_en = vecs[v].rnd;
            drive_req(vecs[v].a, vecs[v].b, vecs[v].lat);
            wait_drain(2000);
            rand_en = 1'b0;
            chk("done_rel", last_done_rel, vecs[v].done_rel);
        end

        // Backpressure: term_ready held low for five cycles after accept.
        term_ready = 1'b0;
        stall_cfg  = 5;
        drive_req(8'h01, 8'h02, 4'd2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("bp_term_valid", int'(term_valid), 1);
            chk("bp_a_idx", int'(term_a_idx), 0);
            chk("bp_b_idx", int'(term_b_idx), 1);
            @(posedge clk); #1;
        end
        term_ready = 1'b1;
        stall_cfg  = 0;
        wait_drain(100);
        chk("bp_done_rel", last_done_rel, 9);

        // Reset in the middle of a request, then a fresh request.
        last_done_rel = -1;
        drive_req(8'h05, 8'h03, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_req_ready", int'(req_ready), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", last_done_rel, -1);
        drive_req(8'h03, 8'h01, 4'd1);
        wait_drain(100);
        chk("post_abort_done_rel", last_done_rel, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitpair_term_scheduler.md
Name: bitpair_term_scheduler

Overview:
Bit-serial partial-product term scheduler for the DCA datapath. It accepts operands A and B through a valid/ready request and walks only the set bits of A (outer loop) and, per A bit, the set bits of B (inner loop). For each nonzero pair it issues one term (bit indices) through a valid/ready handshake, waits a runtime-programmable operation latency, then retires the term. Successor to the fixed-latency, dense-scan scheduler: widths are parametrised, latency is set per request, zero bits are skipped, there is output backpressure, and a signed mode is optional.

Parameters:
A_WIDTH, 8, operand A width (outer loop)
B_WIDTH, 8, operand B width (inner loop)
LAT_WIDTH, 4, width of the per-request latency field

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
enable  input  1  global advance; when low, all state is frozen
req_valid  input  1  request valid
req_ready  output  1  request ready; equals enable while IDLE, otherwise 0
req_a  input  A_WIDTH  operand A
req_b  input  B_WIDTH  operand B
req_latency  input  LAT_WIDTH  cycles from term handshake to retire; 0 is treated as 1
term_valid  output  1  term issue valid
term_ready  input  1  term issue ready
term_a_idx  output  clog2(A_WIDTH)  A bit index of the term
term_b_idx  output  clog2(B_WIDTH)  B bit index of the term
term_neg  output  1  term carries negative weight
retire_pulse  output  1  one-cycle pulse: current term complete
row_done  output  1  one-cycle pulse: last term of the current A bit retired
done  output  1  one-cycle pulse: request fully processed
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; a_mask, b_mask, b_reload, lat_cnt and L cleared; term_valid, retire_pulse, row_done, done, busy and term_neg are 0; term indices are 0; req_ready is 0 during the reset cycle.
- Enable: every register update, transition and pulse is qualified by enable. Pulses are gated low while enable=0. term_valid holds its level, but no handshake counts while enable=0.
- FSM IDLE -> ISSUE | DONE:
  - Accept on req_valid & req_ready. Latch a_mask=req_a, b_reload=req_b, b_mask=req_b, L=max(req_latency,1).
  - If req_a==0 or req_b==0, go to DONE.
- ISSUE:
  - term_valid=1.
  - term_a_idx = lowest set bit of a_mask; term_b_idx = lowest set bit of b_mask.
  - Indices and term_neg stay stable until the handshake.
  - On term_valid & term_ready: lat_cnt=L, go to WAIT.
- WAIT:
  - term_valid=0; lat_cnt decrements each enabled cycle.
  - In the cycle lat_cnt==1: retire_pulse=1 and the lowest bit of b_mask is cleared.
  - If the remaining b_mask is zero: row_done=1, the lowest bit of a_mask is cleared, and b_mask reloads from b_reload.
  - If a_mask is then zero, go to DONE; otherwise go to ISSUE.
  - retire_pulse and row_done may coincide.
- DONE: done=1 for one cycle, then IDLE. req_ready rises the following cycle.
- Timing, with accept at cycle 0 and term_ready=1:
  - first term_valid at cycle 1; handshake at cycle t gives retire at t+L; next term_valid at t+L+1.
  - done at 1 + N*(L+1), where N = popcount(A) * popcount(B).
  - For zero-term requests, done is at cycle 1.
- Exactly one term is in flight at a time. Requests are never accepted while busy.
- Reset mid-operation (rst during any state): IDLE on the next edge. No retire_pulse, row_done or done is emitted for the aborted request.
- Simultaneous rst and req_valid: rst wins and the request is not accepted.

Optional Feature:
Macro BITPAIR_TERM_SCHEDULER_SIGNED_EN.
- Defined: operands are two's complement. term_neg = (term_a_idx==A_WIDTH-1) XOR (term_b_idx==B_WIDTH-1), registered alongside the indices.
- Undefined: term_neg is tied to 0; the port stays present.

Decomposition:
- Shared package bitpair_term_scheduler_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - index-width functions based on clog2;
  - LAT_MIN=1.
- One sub-module, bitpair_ffs: a parametrised lowest-set-bit finder producing a binary index and a nonzero flag. It is instantiated twice, once on a_mask and once on b_mask.

Test Plan:
1. A=8'h05, B=8'h03, latency=3, term_ready=1:
   - terms (0,0), (0,1), (2,0), (2,1) at cycles 1, 5, 9, 13;
   - retires at cycles 4, 8, 12, 16;
   - row_done at cycles 8 and 16;
   - done at cycle 17.
2. A=8'h00, B=8'hFF: done at cycle 1, term_valid never rises; B=8'h00 behaves the same.
3. A=8'h01, B=8'h01, latency=0: term at cycle 1, retire at cycle 2, done at cycle 3 (latency clamped to 1).
4. Backpressure, A=8'h01, B=8'h02, latency=2, term_ready low for cycles 1-5: term_valid held with indices (0,1) stable; handshake at cycle 6, retire at cycle 8, done at cycle 9.
5. rst pulsed at cycle 3 of test 1: busy=0 and req_ready=1 from cycle 4; no retire_pulse or done; a new request is accepted normally.
6. SIGNED_EN defined, A=8'h80, B=8'h81: terms (7,0) with term_neg=1, then (7,7) with term_neg=0; row_done and done once each.
